// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgseq_pkg.sv
// Shared types and constants for the power-gate switch sequencer.
package gf180mcu_fd_sc_mcu7t5v0__pgseq_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_RAMP_UP,
      ST_SETTLE,
      ST_ON,
      ST_ISO,
      ST_RAMP_DOWN
   } pgseq_state_t;

   localparam int unsigned ISO_HOLD_CYC = 2;

   // Timer must hold the longest delay it is ever loaded with.
   function automatic int unsigned timer_width(input int unsigned step_cyc,
                                               input int unsigned settle_cyc);
      int unsigned longest;
      longest = (step_cyc > settle_cyc) ? step_cyc : settle_cyc;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgseq_timer.sv
// Loadable saturating down-counter shared by the step, settle and isolation delays.
module gf180mcu_fd_sc_mcu7t5v0__pgseq_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         expired_c
);

   always_ff @(posedge clk) begin
      if (!rst_n)               count <= '0;
      else if (start)           count <= load_val;
      else if (count != '0)     count <= count - W'(1);
   end

   assign expired_c = (count == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgseq_8.sv
// Power-gate switch sequencer: staggered header enables, settle, then isolation release;
// reverse order on power-down.
module gf180mcu_fd_sc_mcu7t5v0__pgseq_8
   import gf180mcu_fd_sc_mcu7t5v0__pgseq_pkg::*;
#(
   parameter int unsigned N_SW       = 8,
   parameter int unsigned STEP_CYC   = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic            CLK,
   input  logic            RN,
   input  logic            PWR_REQ,
   output logic [N_SW-1:0] SW_EN,
   output logic            PWR_GOOD,
   output logic            ISO_N,
   output logic            BUSY,
   inout  wire             VDD,
   inout  wire             VSS
);

   localparam int unsigned TW = timer_width(STEP_CYC, SETTLE_CYC);
   localparam int unsigned IW = $clog2(N_SW + 1);

   localparam logic [IW-1:0] IDX_FULL  = IW'(N_SW);
   localparam logic [TW-1:0] STEP_LD   = TW'(STEP_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] ISO_LD    = TW'(ISO_HOLD_CYC - 1);
   localparam logic [TW-1:0] STEP_T    = TW'(STEP_CYC);
   localparam logic [TW-1:0] SETTLE_T  = TW'(SETTLE_CYC);

   pgseq_state_t    state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N_SW-1:0] sw_en_d;
   logic            pg_d, iso_d, busy_d;
   logic            step_up, step_dn;
   logic            tmr_start, tmr_exp_c;
   logic [TW-1:0]   tmr_load, tmr_cnt, settle_elapsed;
   logic            unused_rails;

   assign unused_rails = VDD ^ VSS;

   function automatic logic [N_SW-1:0] therm(input logic [IW-1:0] n);
      logic [N_SW-1:0] t;
      for (int i = 0; i < int'(N_SW); i++) t[i] = (IW'(i) < n);
      return t;
   endfunction

   gf180mcu_fd_sc_mcu7t5v0__pgseq_timer #(.W(TW)) u_timer (
      .clk       (CLK),
      .rst_n     (RN),
      .start     (tmr_start),
      .load_val  (tmr_load),
      .count     (tmr_cnt),
      .expired_c (tmr_exp_c)
   );

   // Edges since the last switch set while in SETTLE, used to pace an abort.
   assign settle_elapsed = SETTLE_T - tmr_cnt;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pg_d      = PWR_GOOD;
      iso_d     = ISO_N;
      busy_d    = BUSY;
      step_up   = 1'b0;
      step_dn   = 1'b0;
      tmr_start = 1'b0;
      tmr_load  = STEP_LD;

      case (state_q)
         ST_OFF: begin
            if (PWR_REQ) begin
               step_up = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_RAMP_UP: begin
            if (PWR_REQ) begin
               step_up = tmr_exp_c;
            end else begin
               state_d = ST_RAMP_DOWN;
               step_dn = tmr_exp_c;
            end
         end
         ST_SETTLE: begin
            if (!PWR_REQ) begin
               state_d = ST_RAMP_DOWN;
               if (settle_elapsed >= STEP_T) begin
                  step_dn = 1'b1;
               end else begin
                  tmr_start = 1'b1;
                  tmr_load  = STEP_LD - settle_elapsed;
               end
            end else if (tmr_exp_c) begin
               state_d = ST_ON;
               pg_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         ST_ON: begin
            if (PWR_REQ) begin
               iso_d = PWR_GOOD;
            end else begin
               state_d   = ST_ISO;
               pg_d      = 1'b0;
               iso_d     = 1'b0;
               busy_d    = 1'b1;
               tmr_start = 1'b1;
               tmr_load  = ISO_LD;
            end
         end
         ST_ISO: begin
            step_dn = tmr_exp_c;
         end
         ST_RAMP_DOWN: begin
            // Re-request before any switch dropped: restart the settle period.
            if (PWR_REQ && idx_q == IDX_FULL) begin
               state_d   = ST_SETTLE;
               tmr_start = 1'b1;
               tmr_load  = SETTLE_LD;
            end else if (PWR_REQ) begin
               state_d = ST_RAMP_UP;
               step_up = tmr_exp_c;
            end else begin
               step_dn = tmr_exp_c;
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase

      if (step_up) begin
         idx_d     = idx_q + IW'(1);
         tmr_start = 1'b1;
         tmr_load  = STEP_LD;
         state_d   = ST_RAMP_UP;
         if (idx_q + IW'(1) == IDX_FULL) begin
            state_d  = ST_SETTLE;
            tmr_load = SETTLE_LD;
         end
      end

      if (step_dn) begin
         idx_d     = idx_q - IW'(1);
         tmr_start = 1'b1;
         tmr_load  = STEP_LD;
         state_d   = ST_RAMP_DOWN;
         if (idx_q == IW'(1)) begin
            state_d = ST_OFF;
            busy_d  = 1'b0;
         end
      end

      sw_en_d = therm(idx_d);
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_q  <= ST_OFF;
         idx_q    <= '0;
         SW_EN    <= '0;
         PWR_GOOD <= 1'b0;
         ISO_N    <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         SW_EN    <= sw_en_d;
         PWR_GOOD <= pg_d;
         ISO_N    <= iso_d;
         BUSY     <= busy_d;
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pgseq_8.sv
// Bench for the power-gate sequencer: directed timing checks plus random requests
// against an edge-count model, on the default and the minimal parameter sets.
module tb_gf180mcu_fd_sc_mcu7t5v0__pgseq_8;

   localparam int M_OFF = 0, M_UP = 1, M_SET = 2, M_ON = 3, M_ISO = 4, M_DN = 5;

   typedef struct {
      int mode;
      int n;
      int last;
      int sset;
      int iso0;
      bit pg;
      bit iso;
      bit busy;
   } mdl_t;

   logic       CLK = 1'b0;
   logic       RN = 1'b0;
   logic       PWR_REQ = 1'b0;
   logic [7:0] sw_en8;
   logic       pwr_good8, iso_n8, busy8;
   logic [0:0] sw_en1;
   logic       pwr_good1, iso_n1, busy1;
   wire        vdd, vss;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   int   e = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   k, m, hold;
   mdl_t m8, m1;
   logic [7:0] prev8 = 8'h00;
   logic       rn_s;

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu7t5v0__pgseq_8 dut8 (
      .CLK(CLK), .RN(RN), .PWR_REQ(PWR_REQ), .SW_EN(sw_en8),
      .PWR_GOOD(pwr_good8), .ISO_N(iso_n8), .BUSY(busy8), .VDD(vdd), .VSS(vss)
   );

   gf180mcu_fd_sc_mcu7t5v0__pgseq_8 #(.N_SW(1), .STEP_CYC(1), .SETTLE_CYC(1)) dut1 (
      .CLK(CLK), .RN(RN), .PWR_REQ(PWR_REQ), .SW_EN(sw_en1),
      .PWR_GOOD(pwr_good1), .ISO_N(iso_n1), .BUSY(busy1), .VDD(vdd), .VSS(vss)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
      end
   endtask

   function automatic mdl_t mreset();
      mdl_t r;
      r.mode = M_OFF; r.n = 0; r.last = 0; r.sset = 0; r.iso0 = 0;
      r.pg = 1'b0; r.iso = 1'b0; r.busy = 1'b0;
      return r;
   endfunction

   // Move towards off: a switch drops once a full step has elapsed since the last change.
   function automatic mdl_t go_dn(input mdl_t s, input int ed, input int step);
      mdl_t r = s;
      r.mode = M_DN;
      if (ed - s.last >= step) begin
         r.n    = s.n - 1;
         r.last = ed;
         if (r.n == 0) begin
            r.mode = M_OFF;
            r.busy = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic mdl_t mstep(input mdl_t s, input int ed, input bit rn, input bit req,
                                  input int nsw, input int step, input int settle);
      mdl_t r = s;
      if (!rn) return mreset();
      case (s.mode)
         M_OFF: if (req) begin
            r.busy = 1'b1; r.n = 1; r.last = ed; r.sset = ed;
            r.mode = (nsw == 1) ? M_SET : M_UP;
         end
         M_UP, M_DN: begin
            if (!req) r = go_dn(s, ed, step);
            else if (s.mode == M_DN && s.n == nsw) begin
               r.mode = M_SET; r.sset = ed; r.last = ed;
            end else begin
               r.mode = M_UP;
               if (ed - s.last >= step) begin
                  r.n = s.n + 1; r.last = ed;
                  if (r.n == nsw) begin
                     r.mode = M_SET; r.sset = ed;
                  end
               end
            end
         end
         M_SET: begin
            if (!req) r = go_dn(s, ed, step);
            else if (ed - s.sset >= settle) begin
               r.mode = M_ON; r.pg = 1'b1; r.busy = 1'b0;
            end
         end
         M_ON: begin
            if (req) r.iso = 1'b1;
            else begin
               r.mode = M_ISO; r.pg = 1'b0; r.iso = 1'b0; r.busy = 1'b1; r.iso0 = ed;
            end
         end
         M_ISO: if (ed - s.iso0 >= 2) begin
            r.n = s.n - 1; r.last = ed;
            if (r.n == 0) begin
               r.mode = M_OFF; r.busy = 1'b0;
            end else r.mode = M_DN;
         end
         default: r = mreset();
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      e++;
      rn_s = RN;
      m8 = mstep(m8, e, RN, PWR_REQ, 8, 4, 16);
      m1 = mstep(m1, e, RN, PWR_REQ, 1, 1, 1);
      #1;
      check("sw8",   32'(sw_en8),    32'((1 << m8.n) - 1));
      check("pg8",   32'(pwr_good8), 32'(m8.pg));
      check("iso8",  32'(iso_n8),    32'(m8.iso));
      check("busy8", 32'(busy8),     32'(m8.busy));
      check("sw1",   32'(sw_en1),    32'(m1.n));
      check("pg1",   32'(pwr_good1), 32'(m1.pg));
      check("iso1",  32'(iso_n1),    32'(m1.iso));
      check("busy1", 32'(busy1),     32'(m1.busy));
      check("therm8", 32'((sw_en8 & (sw_en8 + 8'd1)) == 8'd0), 32'd1);
      if (rn_s) check("onebit8", 32'($countones(sw_en8 ^ prev8) <= 1), 32'd1);
      prev8 = sw_en8;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      m8 = mreset();
      m1 = mreset();

      RN = 1'b0; PWR_REQ = 1'b0;
      run(3);
      check("rst_sw", 32'(sw_en8), 32'h0);
      check("rst_iso", 32'(iso_n8), 32'h0);
      RN = 1'b1;
      run(5);

      // Power-up with default timing
      PWR_REQ = 1'b1; k = e + 1;
      for (int i = 0; i <= 46; i++) begin
         tick();
         case (e - k)
            0:  begin check("up_sw0", 32'(sw_en8), 32'h01); check("p1_sw", 32'(sw_en1), 32'h1); end
            1:  check("p1_pg", 32'(pwr_good1), 32'h1);
            2:  check("p1_iso", 32'(iso_n1), 32'h1);
            4:  check("up_sw1", 32'(sw_en8), 32'h03);
            28: check("up_full", 32'(sw_en8), 32'hFF);
            43: begin check("busy43", 32'(busy8), 32'h1); check("pg43", 32'(pwr_good8), 32'h0); end
            44: begin check("pg44", 32'(pwr_good8), 32'h1); check("busy44", 32'(busy8), 32'h0);
                      check("iso44", 32'(iso_n8), 32'h0); end
            45: check("iso45", 32'(iso_n8), 32'h1);
            default: ;
         endcase
      end
      run(10);

      // Power-down from ON
      PWR_REQ = 1'b0; m = e + 1;
      for (int i = 0; i <= 32; i++) begin
         tick();
         case (e - m)
            0:  begin check("dn_iso", 32'(iso_n8), 32'h0); check("dn_pg", 32'(pwr_good8), 32'h0); end
            1:  check("dn_hold", 32'(sw_en8), 32'hFF);
            2:  check("dn_7f", 32'(sw_en8), 32'h7F);
            6:  check("dn_3f", 32'(sw_en8), 32'h3F);
            29: check("dn_busy29", 32'(busy8), 32'h1);
            30: begin check("dn_zero", 32'(sw_en8), 32'h00); check("dn_busy30", 32'(busy8), 32'h0); end
            default: ;
         endcase
      end

      // Abort during ramp-up at 0x07
      PWR_REQ = 1'b1; k = e + 1;
      run(9);
      check("ab_07", 32'(sw_en8), 32'h07);
      PWR_REQ = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         case (e - k)
            11: check("ab_hold", 32'(sw_en8), 32'h07);
            12: check("ab_03", 32'(sw_en8), 32'h03);
            16: check("ab_01", 32'(sw_en8), 32'h01);
            20: check("ab_00", 32'(sw_en8), 32'h00);
            default: ;
         endcase
      end

      // Abort during ramp-down at 0x0F
      PWR_REQ = 1'b1;
      run(50);
      PWR_REQ = 1'b0; m = e + 1;
      run(15);
      check("ad_0f", 32'(sw_en8), 32'h0F);
      PWR_REQ = 1'b1;
      for (int i = 0; i < 34; i++) begin
         tick();
         case (e - m)
            17: check("ad_hold", 32'(sw_en8), 32'h0F);
            18: check("ad_1f", 32'(sw_en8), 32'h1F);
            30: check("ad_ff", 32'(sw_en8), 32'hFF);
            45: check("ad_pg45", 32'(pwr_good8), 32'h0);
            46: check("ad_pg46", 32'(pwr_good8), 32'h1);
            default: ;
         endcase
      end

      // Reset mid ramp-up
      PWR_REQ = 1'b0;
      run(40);
      PWR_REQ = 1'b1; k = e + 1;
      run(17);
      check("rs_1f", 32'(sw_en8), 32'h1F);
      RN = 1'b0;
      tick();
      check("rs_sw", 32'(sw_en8), 32'h00);
      check("rs_busy", 32'(busy8), 32'h0);
      RN = 1'b1;
      tick();
      check("rs_restart", 32'(sw_en8), 32'h01);

      // Random request levels with occasional resets
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            PWR_REQ = ~PWR_REQ;
            hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12))
                                               : int'($urandom_range(20, 70));
         end
         hold--;
         RN = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
